// File: rtl/mul_seq_digit.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one 2x2 digit product per cycle,
// shifted into a 2*WIDTH accumulator, wrapped in a valid/ready handshake.

module mul2x2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] r
);
    assign r = {2'b00, x} * {2'b00, y};
endmodule

module mul_seq_digit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high. in_ready is high only in IDLE; out_valid/product stay stable in DONE
    // until out_ready is seen, and operands are captured only on an IDLE transfer.

    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [PW-1:0]      acc;
    logic [IW-1:0]      i;
    logic [IW-1:0]      j;

    logic [1:0]         a_dig;
    logic [1:0]         b_dig;
    logic [3:0]         r;
    logic [IW+1:0]      sh;
    logic [PW-1:0]      pp;
    logic [PW-1:0]      acc_next;

    assign dbg_state = state;

    always_comb begin
        a_dig    = a_reg[{i, 1'b0} +: 2];
        b_dig    = b_reg[{j, 1'b0} +: 2];
        sh       = {1'b0, i, 1'b0} + {1'b0, j, 1'b0};
        pp       = PW'(r) << sh;
        acc_next = acc + pp;
    end

    mul2x2 u_mul2x2 (
        .x (a_dig),
        .y (b_dig),
        .r (r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            i         <= '0;
            j         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (i == IW'(N - 1)) begin
                        i <= '0;
                        if (j == IW'(N - 1)) begin
                            // Final digit pair: publish the completed sum directly.
                            j         <= '0;
                            product   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_digit.sv
// Bench for mul_seq_digit: directed vectors plus a random stall phase, checked
// through an expected-product queue drained by an independent output monitor.

module tb_mul_seq_digit;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic [1:0]     dbg_state;

    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;
    bit rand_ready = 1'b0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] held;
    bit             held_v = 1'b0;

    mul_seq_digit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
    endtask

    // driver: present one operand pair, hold until accepted
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("issue_timeout");
            return;
        end
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        if (push) begin
            exp_q.push_back((2*W)'(av) * (2*W)'(bv));
            pushed++;
        end
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
    endtask

    // edges after accept until out_valid is first seen
    task automatic measure_latency(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!out_valid && k < 40);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (held_v) check("hold_product", 32'(product), 32'(held));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_product");
                end else begin
                    check("product", 32'(product), 32'(exp_q.pop_front()));
                    popped++;
                end
                held_v = 1'b0;
            end else begin
                held   = product;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // random out_ready stall generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int lat;
        int k;
        int n;
        bit rdy;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        #3;
        check("reset_in_ready", 32'(in_ready), 1);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_product", 32'(product), 0);
        check("reset_state", 32'(dbg_state), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 3 x 5, latency and return to IDLE
        issue(8'd3, 8'd5, 1'b1);
        measure_latency(lat);
        check("latency_3x5", lat, 16);
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 1);
        check("idle_out_valid", 32'(out_valid), 0);

        // extremes
        issue(8'd255, 8'd255, 1'b1);
        measure_latency(lat);
        check("latency_255x255", lat, 16);
        issue(8'd0, 8'd200, 1'b1);
        measure_latency(lat);
        check("latency_0x200", lat, 16);

        // stalled output holds value
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(8'hA5, 8'h3C, 1'b1);
        wait_out_valid();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_product", 32'(product), 9900);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(out_valid), 0);

        // in_valid while BUSY is ignored until IDLE
        issue(8'd33, 8'd19, 1'b1);
        in_valid = 1'b1;
        a        = 8'd7;
        b        = 8'd7;
        k        = 0;
        rdy      = 1'b0;
        while (!rdy && k < 40) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            k++;
        end
        if (rdy) begin
            exp_q.push_back(16'd49);
            pushed++;
        end
        #1 in_valid = 1'b0;
        check("second_accept_edge", k, 18);
        wait_out_valid();

        // async reset mid-BUSY discards the operation
        issue(8'd200, 8'd3, 1'b0);
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 0);
        check("midreset_in_ready", 32'(in_ready), 1);
        check("midreset_product", 32'(product), 0);
        check("midreset_state", 32'(dbg_state), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(8'd12, 8'd12, 1'b1);
        measure_latency(lat);
        check("latency_12x12", lat, 16);

        // back-to-back with random stalls
        rand_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            issue(W'($urandom), W'($urandom), 1'b1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rand_ready = 1'b0;
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("pushed_eq_popped", popped, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_seq_digit.md
Name: mul_seq_digit

Overview:
- Iterative unsigned WIDTH x WIDTH multiplier built on a single mul2x2 instance.
- Each BUSY cycle it selects one 2-bit digit of each operand and feeds the pair to mul2x2. It then shifts the 4-bit partial product and adds it into a 2*WIDTH accumulator.
- Sits directly upstream of mul2x2 as its operand sequencer and consumer.
- Provides a valid/ready wrapped multiply for datapath users that cannot afford a full array multiplier.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- Derived (not overridable): N = WIDTH/2 digits per operand; N*N BUSY cycles per operation.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  unsigned multiplicand.
- b  input  WIDTH  unsigned multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  unsigned a*b.

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is asynchronous and active-high. While rst is high:
  - state=IDLE, in_ready=1, out_valid=0, product=0;
  - accumulator, digit indices i/j and operand registers all 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a and b, clear accumulator, set i=0, j=0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - mul2x2 inputs: a_reg[2i+1:2i] and b_reg[2j+1:2j].
  - Each edge: acc <= acc + (zero-extended r << 2*(i+j)).
  - Index update: i increments; when i==N-1, i wraps to 0 and j increments.
  - On the edge where i==N-1 and j==N-1, the final add happens and state goes to DONE.
  - Exactly N*N adds, always; no early termination on zero operands.
- DONE:
  - out_valid=1, product=acc, in_ready=0.
  - product and out_valid hold stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
- Latency: operands accepted at edge E0, so out_valid is first high in the cycle after edge E0+N*N. For WIDTH=8 that is 16 edges.
- Minimum issue interval is N*N+2 cycles. in_ready is high only in IDLE; there is no accept in the same cycle as product handoff.
- Arithmetic and widths:
  - Accumulator is 2*WIDTH bits and cannot overflow, since max (2^W-1)^2 < 2^(2W).
  - Partial-product shift amount is at most 2*(WIDTH-2).
- Handshake inputs out of state:
  - in_valid while BUSY or DONE is ignored; operands are not captured.
  - out_ready while not in DONE has no effect.
- product is a registered copy of acc. It is updated only on the BUSY->DONE transition and cleared by reset.
  - Value in IDLE/BUSY: holds the last completed product, which is don't-care for consumers since out_valid=0.
- Reset mid-operation (BUSY or DONE): the async clear takes effect immediately. The pending result is discarded and the block resumes in IDLE after rst falls.
- Operand registers are not sensitive to input changes after acceptance; a and b may change freely during BUSY.

Test Plan:
1. WIDTH=8: a=3, b=5, in_valid for one cycle, out_ready=1 -> out_valid rises exactly 16 edges after accept; product=15; then returns to IDLE with in_ready=1.
2. a=255, b=255 -> product=65025 (0xFE01); a=0, b=200 -> product=0 with the same 16-edge latency.
3. a=0xA5, b=0x3C; out_ready held 0 for 10 cycles after out_valid -> product=9900 (0x26AC) stable and out_valid high throughout; one cycle of out_ready=1 -> out_valid=0 next cycle.
4. While BUSY, drive in_valid=1 with a=7, b=7; change the accepted operands' a/b pins -> result equals the originally accepted a*b, and the second pair is not processed until IDLE.
5. Assert rst asynchronously mid-BUSY, at edge 8 of 16 -> out_valid=0, in_ready=1, product=0 immediately. After release, a=12, b=12 -> product=144 with the normal latency.
6. Randomised back-to-back: 200 operations with random a/b and random out_ready stalls -> every product matches a*b, and no operation is lost or duplicated.
